// File: rtl/apb_master_bridge.sv
// Core request/grant/rvalid to APB3 master bridge, one transfer in flight.
// Optional ACCESS-phase timeout when APB_BRIDGE_TIMEOUT_EN is defined (limit TIMEOUT_CYCLES).
module apb_master_bridge #(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_i,
  input  logic                      we_i,
  input  logic [APB_ADDR_WIDTH-1:0] addr_i,
  input  logic [APB_DATA_WIDTH-1:0] wdata_i,
  output logic                      gnt_o,
  output logic                      rvalid_o,
  output logic [APB_DATA_WIDTH-1:0] rdata_o,
  output logic                      err_o,
  output logic [APB_ADDR_WIDTH-1:0] paddr_o,
  output logic [APB_DATA_WIDTH-1:0] pwdata_o,
  output logic                      pwrite_o,
  output logic                      psel_o,
  output logic                      penable_o,
  input  logic [APB_DATA_WIDTH-1:0] prdata_i,
  input  logic                      pready_i,
  input  logic                      pslverr_i
);

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_t;
  state_t state;

`ifdef APB_BRIDGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt;
`endif

  // Grant is the only combinational output; everything APB-facing is registered.
  assign gnt_o = req_i && (state == IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      psel_o    <= 1'b0;
      penable_o <= 1'b0;
      pwrite_o  <= 1'b0;
      paddr_o   <= '0;
      pwdata_o  <= '0;
      rvalid_o  <= 1'b0;
      rdata_o   <= '0;
      err_o     <= 1'b0;
`ifdef APB_BRIDGE_TIMEOUT_EN
      cnt       <= '0;
`endif
    end else begin
      rvalid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req_i) begin
            paddr_o   <= addr_i;
            pwrite_o  <= we_i;
            pwdata_o  <= wdata_i;
            psel_o    <= 1'b1;
            penable_o <= 1'b0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          penable_o <= 1'b1;
          state     <= ACCESS;
`ifdef APB_BRIDGE_TIMEOUT_EN
          cnt       <= '0;
`endif
        end
        ACCESS: begin
          if (pready_i) begin
            rvalid_o  <= 1'b1;
            rdata_o   <= pwrite_o ? '0 : prdata_i;
            err_o     <= pslverr_i;
            psel_o    <= 1'b0;
            penable_o <= 1'b0;
            state     <= IDLE;
          end
`ifdef APB_BRIDGE_TIMEOUT_EN
          // Last allowed wait cycle without ready: abort with an error response.
          else if (cnt == CNT_LAST) begin
            rvalid_o  <= 1'b1;
            rdata_o   <= '0;
            err_o     <= 1'b1;
            psel_o    <= 1'b0;
            penable_o <= 1'b0;
            state     <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
`endif
        end
        default: begin
          psel_o    <= 1'b0;
          penable_o <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Randomized bench for apb_master_bridge: transaction-timeline model plus directed literal checks.
module tb_apb_master_bridge;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst, req, we, pready, pslverr;
  logic [31:0] addr, wdata, prdata;
  logic        gnt, rvalid, err, pwrite, psel, penable;
  logic [31:0] rdata, paddr, pwdata;

  int total = 0;
  int bad = 0;

  apb_master_bridge #(
    .APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err),
    .paddr_o(paddr), .pwdata_o(pwdata), .pwrite_o(pwrite), .psel_o(psel), .penable_o(penable),
    .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: a transaction is "busy" from the cycle after its grant; k counts cycles since grant
  // (k=1 setup, k>=2 access). Response appears the cycle after the completing access cycle.
  logic        m_init = 1'b0;
  logic        m_busy, m_we, m_rvalid, m_err;
  int          m_k;
  logic [31:0] m_addr, m_wdata, m_rdata;

  initial begin : model
    forever begin
      @(negedge clk);
      if (m_init) begin
        chk("gnt", gnt, 32'(!m_busy && req));
        chk("psel", psel, 32'(m_busy));
        chk("penable", penable, 32'(m_busy && m_k >= 2));
        chk("rvalid", rvalid, 32'(m_rvalid));
        chk("rdata", rdata, m_rdata);
        chk("err", err, 32'(m_err));
        chk("paddr", paddr, m_addr);
        chk("pwdata", pwdata, m_wdata);
        chk("pwrite", pwrite, 32'(m_we));
      end
      m_init = 1'b1;
      m_rvalid = 1'b0;
      if (rst) begin
        m_busy = 0; m_k = 0; m_we = 0; m_err = 0;
        m_addr = 0; m_wdata = 0; m_rdata = 0;
      end else if (!m_busy) begin
        if (req) begin
          m_busy = 1; m_k = 1; m_addr = addr; m_we = we; m_wdata = wdata;
        end
      end else if (m_k == 1) begin
        m_k = 2;
      end else if (pready) begin
        m_rvalid = 1; m_rdata = m_we ? 32'h0 : prdata; m_err = pslverr; m_busy = 0;
      end
`ifdef APB_BRIDGE_TIMEOUT_EN
      else if (m_k - 2 == TMO - 1) begin
        m_rvalid = 1; m_rdata = 0; m_err = 1; m_busy = 0;
      end
`endif
      else begin
        m_k++;
      end
    end
  end

  task automatic read0(input logic [31:0] a, input logic [31:0] d, input logic e, input string tag);
    req = 1; we = 0; addr = a; prdata = d; pready = 1; pslverr = e;
    @(negedge clk); chk({tag, "_gnt0"}, gnt, 1);
    step(); req = 0;
    @(negedge clk); chk({tag, "_psel1"}, psel, 1); chk({tag, "_pen1"}, penable, 0);
    step();
    @(negedge clk); chk({tag, "_pen2"}, penable, 1); chk({tag, "_rv2"}, rvalid, 0);
    step(); pslverr = 0;
    @(negedge clk);
    chk({tag, "_rv3"}, rvalid, 1); chk({tag, "_rd3"}, rdata, d);
    chk({tag, "_err3"}, err, 32'(e)); chk({tag, "_psel3"}, psel, 0);
    step();
    @(negedge clk); chk({tag, "_rv4"}, rvalid, 0);
    step();
  endtask

  initial begin : stim
    int stuck;
    stuck = 0;
    rst = 1; req = 0; we = 0; addr = 0; wdata = 0; prdata = 0; pready = 0; pslverr = 0;
    step(); step();
    rst = 0;
    @(negedge clk);
    chk("rst_psel", psel, 0); chk("rst_pen", penable, 0); chk("rst_rv", rvalid, 0);
    chk("rst_paddr", paddr, 0); chk("rst_rdata", rdata, 0); chk("rst_err", err, 0);
    step();

    read0(32'h1A10_0000, 32'hCAFE_F00D, 1'b0, "rd0");

    // write, 4 wait states
    req = 1; we = 1; addr = 32'h1A10_0040; wdata = 32'h1234_5678; pready = 0; prdata = 32'hDEAD_BEEF;
    @(negedge clk); chk("wr_gnt", gnt, 1);
    step(); req = 0; wdata = 32'h0; addr = 32'h0;
    for (int c = 1; c <= 6; c++) begin
      pready = (c == 6);
      @(negedge clk);
      chk("wr_pwdata", pwdata, 32'h1234_5678); chk("wr_paddr", paddr, 32'h1A10_0040);
      chk("wr_psel", psel, 1); chk("wr_rv", rvalid, 0);
      step();
    end
    pready = 0;
    @(negedge clk); chk("wr_rv7", rvalid, 1); chk("wr_rd7", rdata, 0); chk("wr_err7", err, 0);
    step();

    read0(32'h1A10_0008, 32'h5555_AAAA, 1'b1, "slverr");

    // back-to-back, zero wait
    req = 1; we = 0; addr = 32'h1A10_0100; prdata = 32'h0BAD_CAFE; pready = 1;
    for (int c = 0; c <= 9; c++) begin
      if (c == 7) req = 0;
      @(negedge clk);
      chk("b2b_gnt", gnt, 32'(c % 3 == 0 && c <= 6));
      chk("b2b_rv", rvalid, 32'(c % 3 == 0 && c >= 3));
      step();
    end
    pready = 0;

    // reset while waiting in ACCESS
    req = 1; we = 0; addr = 32'h1A10_0200;
    step(); req = 0;
    step();
    @(negedge clk); chk("rstacc_pen", penable, 1);
    step(); rst = 1;
    step(); rst = 0;
    @(negedge clk); chk("rstacc_psel", psel, 0); chk("rstacc_pen0", penable, 0); chk("rstacc_rv", rvalid, 0);
    step();
    @(negedge clk); chk("rstacc_rv2", rvalid, 0);
    step();
    read0(32'h1A10_0300, 32'h7777_0001, 1'b0, "postrst");

`ifdef APB_BRIDGE_TIMEOUT_EN
    req = 1; we = 0; addr = 32'h1A10_0400; pready = 0; prdata = 32'hFFFF_FFFF;
    step(); req = 0;
    step();
    for (int c = 2; c <= 9; c++) begin
      @(negedge clk); chk("tmo_pen", penable, 1); chk("tmo_rv", rvalid, 0);
      step();
    end
    @(negedge clk);
    chk("tmo_rv10", rvalid, 1); chk("tmo_err", err, 1); chk("tmo_rd", rdata, 0); chk("tmo_psel", psel, 0);
    step();
`endif

    for (int c = 0; c < 3000; c++) begin
      rst     = ($urandom_range(0, 299) == 0);
      req     = ($urandom_range(0, 9) < 6);
      we      = 1'($urandom);
      addr    = $urandom;
      wdata   = $urandom;
      prdata  = $urandom;
      pslverr = ($urandom_range(0, 3) == 0);
      if (stuck == 0 && $urandom_range(0, 99) == 0) stuck = 12;
      if (stuck > 0) begin
        pready = 0;
        stuck--;
      end else begin
        pready = ($urandom_range(0, 2) != 0);
      end
      step();
    end
    rst = 0; req = 0; pready = 1;
    step(); step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
